// File: rtl/mplc_fetch_seq_pkg.sv
// Shared instruction-word layout, opcode set and sequencer state encoding
// for the multi-core logic unit fetch path.
package mplc_fetch_seq_pkg;

  localparam int unsigned OPC_MSB = 17;
  localparam int unsigned OPC_LSB = 14;
  localparam int unsigned MOD_MSB = 13;
  localparam int unsigned MOD_LSB = 12;
  localparam int unsigned OPR_MSB = 11;
  localparam int unsigned OPR_LSB = 0;

  typedef enum logic [3:0] {
    I_NOP  = 4'h0,
    I_LD   = 4'h1,
    I_LDN  = 4'h2,
    I_ST   = 4'h3,
    I_STN  = 4'h4,
    I_AND  = 4'h5,
    I_OR   = 4'h6,
    I_XOR  = 4'h7,
    I_SET  = 4'h8,
    I_RST  = 4'h9,
    I_JMP  = 4'hE,
    I_JMPC = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  function automatic logic [3:0] get_opc(input logic [17:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/mplc_scan_wdog.sv
// Per-scan issue counter; ovf strobes when an issue request would push the
// count past MAX_STEPS, in which case the count is left untouched.
module mplc_scan_wdog #(
  parameter int unsigned MAX_STEPS = 4095,
  parameter int unsigned CW        = $clog2(MAX_STEPS + 1)
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr,
  input  logic inc,
  output logic ovf
);

  logic [CW-1:0] cnt_q;

  assign ovf = inc && (cnt_q == CW'(MAX_STEPS));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      cnt_q <= '0;
    else if (clr)
      cnt_q <= '0;
    else if (inc && !ovf)
      cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/mplc_fetch_seq.sv
// Instruction fetch/sequencer: resolves JMP/JMPC locally, issues all other
// words to execute over valid/ready, and marks/guards scan cycles.
module mplc_fetch_seq
  import mplc_fetch_seq_pkg::*;
#(
  parameter int unsigned    DW        = 18,
  parameter int unsigned    AW        = 12,
  parameter int unsigned    MAX_STEPS = 4095,
  parameter logic [AW-1:0]  END_ADDR  = '1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          RUN,
  output logic [AW-1:0] MA,
  input  logic [DW-1:0] MQ,
  output logic [DW-1:0] INSTR,
  output logic          INSTR_VLD,
  input  logic          INSTR_RDY,
  input  logic          COND,
  output logic [AW-1:0] PC,
  output logic          SCAN_DONE,
  output logic          FAULT
);

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] instr_q, instr_d;
  logic          vld_q, vld_d;
  logic          done_q, done_d;
  logic          fault_q, fault_d;

  logic [3:0]    opc;
  logic [AW-1:0] target;
  logic          slot_free, is_jump, issue_req, wd_clr, wd_ovf;

  assign opc       = get_opc(MQ);
  assign target    = MQ[AW-1:0];
  assign slot_free = !vld_q || INSTR_RDY;
  assign is_jump   = (opc == I_JMP) || (opc == I_JMPC);
  // Kept outside the decode block so the watchdog strobe does not loop back.
  assign issue_req = RUN && (state_q == S_FETCH) && slot_free && !is_jump;

  mplc_scan_wdog #(
    .MAX_STEPS(MAX_STEPS)
  ) u_wdog (
    .CLK  (CLK),
    .RST_N(RST_N),
    .clr  (wd_clr),
    .inc  (issue_req),
    .ovf  (wd_ovf)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
    fault_d = fault_q;
    wd_clr  = 1'b0;
    if (!RUN) begin
      state_d = S_IDLE;
      pc_d    = '0;
      vld_d   = 1'b0;
      fault_d = 1'b0;
      wd_clr  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
        S_FETCH: begin
          if (slot_free) begin
            vld_d = 1'b0;
            // JMPC waits until the slot is empty so COND reflects the last accept.
            if ((opc == I_JMP) || ((opc == I_JMPC) && !vld_q && COND)) begin
              if (target == END_ADDR) begin
                done_d = 1'b1;
                pc_d   = '0;
                wd_clr = 1'b1;
              end else begin
                pc_d = target;
              end
            end else if (opc == I_JMPC) begin
              if (!vld_q)
                pc_d = pc_q + 1'b1;
            end else if (wd_ovf) begin
              fault_d = 1'b1;
              state_d = S_HALT;
            end else begin
              instr_d = MQ;
              vld_d   = 1'b1;
              pc_d    = pc_q + 1'b1;
              if (pc_q == '1) begin
                done_d = 1'b1;
                wd_clr = 1'b1;
              end
            end
          end
        end
        S_HALT: begin
          vld_d = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  assign MA        = pc_q;
  assign PC        = pc_q;
  assign INSTR     = instr_q;
  assign INSTR_VLD = vld_q;
  assign SCAN_DONE = done_q;
  assign FAULT     = fault_q;

endmodule

// File: doc/mplc_fetch_seq.md
Name: mplc_fetch_seq

Overview:
Instruction fetch/sequencer for the multi-core logic unit. It reads the 18-bit program words from prog_bit_mem through that memory's combinational read port. It resolves JMP and JMPC locally, and hands every other instruction to the execute stage over a valid/ready handshake. It marks scan-cycle boundaries and guards each scan with a step-count watchdog.

Parameters:
DW, 18, program word width {opcode, modifier, 12-bit operand}
AW, 12, program address width
MAX_STEPS, 4095, maximum instructions issued per scan before FAULT
END_ADDR, {AW{1'b1}}, JMP target that means end of scan

Ports:
CLK  in  1  clock; all state updates on the rising edge
RST_N  in  1  asynchronous active-low reset
RUN  in  1  level; 1 = execute program, 0 = stop and return to IDLE
MA  out  AW  program memory address (drives prog_bit_mem A)
MQ  in  DW  program memory read data, combinational from MA
INSTR  out  DW  issued instruction word
INSTR_VLD  out  1  INSTR valid
INSTR_RDY  in  1  execute accepts INSTR when VLD&RDY at an edge
COND  in  1  execute accumulator; valid one cycle after acceptance
PC  out  AW  address of the word currently on MQ
SCAN_DONE  out  1  one-cycle pulse at end of scan
FAULT  out  1  sticky watchdog fault

Behaviour:
- Reset: state IDLE; PC=0; MA=0; INSTR=0; INSTR_VLD=0; SCAN_DONE=0; FAULT=0; step counter=0.
- MA=PC at all times. MQ is used in the same cycle, giving zero-cycle memory latency.
- IDLE: INSTR_VLD=0 and PC held at 0. RUN=1 -> FETCH.
- FETCH, when the slot is free (INSTR_VLD=0, or VLD&RDY at this edge), decode the MQ opcode:
  - JMP, target=END_ADDR: SCAN_DONE=1 next cycle; PC<=0; step counter<=0; nothing issued.
  - JMP, other target: PC<=target; nothing issued.
  - JMPC: evaluated only when INSTR_VLD=0 and no acceptance occurred in the previous cycle, so COND is current. Otherwise wait (one-cycle bubble). When taken (COND=1) PC<=target, else PC<=PC+1. Nothing issued. A JMPC target of END_ADDR behaves as the end-of-scan JMP.
  - Any other opcode, including NOP with modifiers: INSTR<=MQ; INSTR_VLD<=1; PC<=PC+1; step counter+1.
- Holding: while INSTR_VLD=1 and INSTR_RDY=0, INSTR, INSTR_VLD and PC stay stable.
- Throughput: one non-jump instruction per cycle when INSTR_RDY is held at 1. Each jump costs one cycle; a JMPC directly after an issue costs two.
- PC wrap: a non-jump at address 2^AW-1 wraps PC to 0 and is treated as end of scan (SCAN_DONE pulse, counter cleared).
- Watchdog: an issue that would make the counter exceed MAX_STEPS instead sets FAULT=1 and moves to HALT, with INSTR_VLD<=0.
- HALT: no fetches, FAULT held. RUN=0 -> IDLE and FAULT cleared.
- RUN=0 in any state: next edge -> IDLE, INSTR_VLD<=0 (an unaccepted instruction is discarded), PC<=0, counter<=0. If VLD&RDY fall on that same edge, the acceptance still counts.
- SCAN_DONE and an issue never coincide, since jumps are not issued.
- Writes to program memory while RUN=1 are undefined; the loader must drop RUN first.

Decomposition:
- Opcode/modifier field positions, opcode constants (I_JMP, I_JMPC, I_NOP...) and state encodings go in the shared instruction header mplc_logic_il.v. No local literals.
- Sub-module mplc_scan_wdog: step counter with clear/inc/limit compare, producing the overflow strobe.
- The FSM (IDLE/FETCH/HALT) and PC datapath stay in mplc_fetch_seq.

Test Plan:
- Program LD 000, OR 001, ST 006, JMP fff; RDY=1; RUN 0->1 -> issues at PC 0,1,2 in consecutive cycles; SCAN_DONE pulse; PC returns to 0; repeats.
- Same program, RDY low for 3 cycles on the second instruction -> INSTR=OR 001 held stable, PC=2 held, no duplicate issue.
- Program LD 000, JMPC 005, ST 006, ..., 005: ST 007; COND=1 after LD accept -> next issue is from PC 5. COND=0 -> next issue is from PC 2, with the one-cycle bubble.
- MAX_STEPS=4; program of 6 NOPs then JMP fff -> 4 issues, then FAULT=1 and INSTR_VLD=0. RUN=0 clears FAULT; RUN=1 restarts at PC 0.
- RUN dropped while INSTR_VLD=1, RDY=0 -> next edge INSTR_VLD=0, PC=0, no SCAN_DONE.
- Async RST_N asserted mid-scan between edges -> all outputs zero immediately; restart fetches from PC 0.
